// File: rtl/pc_unit_if.sv
// Bundle of control inputs and PC/status outputs for the program-counter stage.
// Optional counters taken_cnt/jump_cnt exist only when PC_BRANCH_STATS_EN is defined.
interface pc_unit_if;
    logic        pcsrc;
    logic        jump;
    logic        jr;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] rs_val;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] retired;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] jump_cnt;

    modport master (
        output pcsrc, jump, jr, imm, jidx, rs_val, stall,
        input  pc, pc_plus4, fetch_valid, fault, fault_pc, retired,
        input  taken_cnt, jump_cnt
    );

    modport slave (
        input  pcsrc, jump, jr, imm, jidx, rs_val, stall,
        output pc, pc_plus4, fetch_valid, fault, fault_pc, retired,
        output taken_cnt, jump_cnt
    );
`else
    modport master (
        output pcsrc, jump, jr, imm, jidx, rs_val, stall,
        input  pc, pc_plus4, fetch_valid, fault, fault_pc, retired
    );

    modport slave (
        input  pcsrc, jump, jr, imm, jidx, rs_val, stall,
        output pc, pc_plus4, fetch_valid, fault, fault_pc, retired
    );
`endif
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC selection, post-reset hold, stall, misaligned-jr fault capture.
// Optional branch/jump statistics are compiled in with PC_BRANCH_STATS_EN.
module pc_unit #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter int unsigned RESET_HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_N      = 4'(RESET_HOLD_CYCLES);
    localparam state_t     RESET_STATE = (RESET_HOLD_CYCLES == 0) ? ST_RUN : ST_HOLD;

    state_t      state,    state_n;
    logic [31:0] pc_q,     pc_n;
    logic [31:0] fpc_q,    fpc_n;
    logic [31:0] ret_q,    ret_n;
    logic [3:0]  hold_cnt, hold_n;

    logic [31:0] pc_plus4;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic [31:0] target;
    logic        sel_taken;
    logic        sel_jump;
    logic        misaligned;
    logic        update;

    assign pc_plus4 = pc_q + 32'd4;
    assign btarget  = pc_plus4 + {{14{bus.imm[15]}}, bus.imm, 2'b00};
    assign jtarget  = {pc_plus4[31:28], bus.jidx, 2'b00};

    // Fixed priority jr > jump > pcsrc > sequential; only the jr path can be misaligned.
    always_comb begin
        target    = pc_plus4;
        sel_taken = 1'b0;
        sel_jump  = 1'b0;
        if (bus.jr) begin
            target   = bus.rs_val;
            sel_jump = 1'b1;
        end else if (bus.jump) begin
            target   = jtarget;
            sel_jump = 1'b1;
        end else if (bus.pcsrc) begin
            target    = btarget;
            sel_taken = 1'b1;
        end
        misaligned = (target[1:0] != 2'b00);
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        fpc_n   = fpc_q;
        ret_n   = ret_q;
        hold_n  = hold_cnt;
        update  = 1'b0;
        case (state)
            ST_HOLD: begin
                if (hold_cnt + 4'd1 >= HOLD_N) begin
                    state_n = ST_RUN;
                    hold_n  = 4'd0;
                end else begin
                    hold_n  = hold_cnt + 4'd1;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    if (misaligned) begin
                        state_n = ST_FAULT;
                        fpc_n   = bus.rs_val;
                    end else begin
                        pc_n   = target;
                        ret_n  = ret_q + 32'd1;
                        update = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RESET_STATE;
            pc_q     <= RESET_PC;
            fpc_q    <= 32'd0;
            ret_q    <= 32'd0;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            fpc_q    <= fpc_n;
            ret_q    <= ret_n;
            hold_cnt <= hold_n;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = (state == ST_RUN);
    assign bus.fault       = (state == ST_FAULT);
    assign bus.fault_pc    = fpc_q;
    assign bus.retired     = ret_q;

`ifdef PC_BRANCH_STATS_EN
    logic [15:0] taken_q, taken_n;
    logic [15:0] jcnt_q,  jcnt_n;

    // Counters only move on a committed update and stick at all-ones.
    always_comb begin
        taken_n = taken_q;
        jcnt_n  = jcnt_q;
        if (update && sel_taken && (taken_q != 16'hFFFF))
            taken_n = taken_q + 16'd1;
        if (update && sel_jump && (jcnt_q != 16'hFFFF))
            jcnt_n = jcnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q <= 16'd0;
            jcnt_q  <= 16'd0;
        end else begin
            taken_q <= taken_n;
            jcnt_q  <= jcnt_n;
        end
    end

    assign bus.taken_cnt = taken_q;
    assign bus.jump_cnt  = jcnt_q;
`else
    logic unused_sel;
    assign unused_sel = update & sel_taken & sel_jump;
`endif

endmodule
